// File: rtl/vdp_g1_render.sv
// vdp_g1_render
//   Graphics I (TMS9918 mode 0) pixel renderer. Follows the VGA sync
//   generator, fetches name/pattern/color bytes for each 8-pixel tile over a
//   single VRAM read port during the 16 clocks before that tile is shown, and
//   emits a registered, pixel-doubled 4-bit color index (256x192 -> 512x384).
//
// Ports
//   clk, reset          pixel clock, asynchronous active-low reset
//   col, row            beam position from the sync generator
//   vid_active, bdr_active, hsync, vsync   sync generator status, same cycle
//   r1_blank_n          0 = display blanked
//   r2_nt, r3_ct, r4_pg name table / color table / pattern generator bases
//   r7_bd               backdrop color
//   vram_addr, vram_rd  VRAM read address and one-clock read strobe
//   vram_data           read data, valid the clock after vram_rd
//   color               pixel color index, one clock behind col
//   hsync_o, vsync_o, vid_o   sync inputs delayed one clock
module vdp_g1_render #(
    parameter int HVID_BEGIN = 64,
    parameter int VVID_BEGIN = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  col,
    input  logic [9:0]  row,
    input  logic        vid_active,
    input  logic        bdr_active,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        r1_blank_n,
    input  logic [3:0]  r2_nt,
    input  logic [7:0]  r3_ct,
    input  logic [2:0]  r4_pg,
    input  logic [3:0]  r7_bd,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    input  logic [7:0]  vram_data,
    output logic [3:0]  color,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        vid_o
);

    localparam logic [9:0] FETCH_BEGIN = 10'(HVID_BEGIN - 16);
    localparam logic [9:0] HBEGIN      = 10'(HVID_BEGIN);
    localparam logic [9:0] VBEGIN      = 10'(VVID_BEGIN);
    localparam logic [9:0] VLINES      = 10'd384;

    logic [9:0]  f;
    logic [9:0]  vy;
    logic [7:0]  y;
    logic [4:0]  n;
    logic [3:0]  p;
    logic        fetch_en;
    logic        px_odd;
    logic [13:0] addr_q;
    logic [7:0]  name_q;
    logic [7:0]  pattern_q;
    logic [7:0]  colbyte_q;
    logic [7:0]  shifter;
    logic [3:0]  fg;
    logic [3:0]  bg;
    logic [3:0]  pix;

    // Unsigned wrap makes rows/cols before the window land at large values,
    // so a single upper-bound test covers both ends of each range.
    assign f  = col - FETCH_BEGIN;
    assign vy = row - VBEGIN;
    assign y  = vy[8:1];
    assign n  = f[8:4];
    assign p  = f[3:0];

    // Gated by reset so the port stays quiet while reset is held.
    assign fetch_en = reset && r1_blank_n && (vy < VLINES) && !f[9];
    assign px_odd   = col[0] ^ HBEGIN[0];

    // Address is driven combinationally in the access phase so the data
    // returns exactly one clock later; otherwise the last address is held.
    always_comb begin
        vram_rd   = 1'b0;
        vram_addr = addr_q;
        if (fetch_en) begin
            case (p)
                4'd0: begin
                    vram_rd   = 1'b1;
                    vram_addr = {r2_nt, y[7:3], n};
                end
                4'd2: begin
                    vram_rd   = 1'b1;
                    vram_addr = {r4_pg, name_q, y[2:0]};
                end
                4'd3: begin
                    vram_rd   = 1'b1;
                    vram_addr = {r3_ct, 1'b0, name_q[7:3]};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            name_q    <= '0;
            pattern_q <= '0;
            colbyte_q <= '0;
        end else begin
            addr_q <= vram_addr;
            if (fetch_en) begin
                case (p)
                    4'd1:    name_q    <= vram_data;
                    4'd3:    pattern_q <= vram_data;
                    4'd4:    colbyte_q <= vram_data;
                    default: ;
                endcase
            end
        end
    end

    // Load at phase 15 wins over the shift that falls on the same clock
    // (last odd column of the previous tile).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shifter <= '0;
            fg      <= '0;
            bg      <= '0;
        end else if (fetch_en && p == 4'd15) begin
            shifter <= pattern_q;
            fg      <= colbyte_q[7:4];
            bg      <= colbyte_q[3:0];
        end else if (vid_active && px_odd) begin
            shifter <= {shifter[6:0], 1'b0};
        end
    end

    assign pix = shifter[7] ? fg : bg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            color   <= '0;
            hsync_o <= 1'b0;
            vsync_o <= 1'b0;
            vid_o   <= 1'b0;
        end else begin
            hsync_o <= hsync;
            vsync_o <= vsync;
            vid_o   <= vid_active;
            if (vid_active) begin
                if (r1_blank_n)
                    color <= (pix == 4'd0) ? r7_bd : pix;
                else
                    color <= r7_bd;
            end else if (bdr_active) begin
                color <= r7_bd;
            end else begin
                color <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vdp_g1_render.sv
// tb_vdp_g1_render
//   Directed bench for vdp_g1_render. A behavioural sync generator drives
//   whole lines; a behavioural VRAM answers reads one clock later. Expected
//   pixel/sync outputs come from a frame-level golden model, are queued when
//   each column is driven and compared when the registered output appears.
module tb_vdp_g1_render;

    localparam int HV = 64;
    localparam int VV = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  col, row;
    logic        vid_active, bdr_active, hsync, vsync;
    logic        r1_blank_n;
    logic [3:0]  r2_nt;
    logic [7:0]  r3_ct;
    logic [2:0]  r4_pg;
    logic [3:0]  r7_bd;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic [7:0]  vram_data = '0;
    logic [3:0]  color;
    logic        hsync_o, vsync_o, vid_o;

    logic [7:0]  mem [0:16383];

    typedef struct {
        logic [3:0] color;
        logic       hs;
        logic       vs;
        logic       vid;
        bit         chk;
        int         col;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          rd_count;
    int          rd_seen;
    logic [13:0] rd_addrs [3];
    logic [3:0]  obs [16];

    always #5 clk = ~clk;

    always @(posedge clk) if (vram_rd) vram_data <= mem[vram_addr];

    vdp_g1_render #(.HVID_BEGIN(HV), .VVID_BEGIN(VV)) dut (
        .clk(clk), .reset(reset), .col(col), .row(row),
        .vid_active(vid_active), .bdr_active(bdr_active),
        .hsync(hsync), .vsync(vsync), .r1_blank_n(r1_blank_n),
        .r2_nt(r2_nt), .r3_ct(r3_ct), .r4_pg(r4_pg), .r7_bd(r7_bd),
        .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_data(vram_data),
        .color(color), .hsync_o(hsync_o), .vsync_o(vsync_o), .vid_o(vid_o)
    );

    function automatic bit f_vid(int c, int r);
        return c >= HV && c < HV + 512 && r >= VV && r < VV + 384;
    endfunction
    function automatic bit f_bdr(int c, int r);
        return !f_vid(c, r) && c >= 32 && c < 608 && r >= 24 && r < 456;
    endfunction
    function automatic bit f_hs(int c);
        return c >= 656 && c < 752;
    endfunction
    function automatic bit f_vs(int r);
        return r >= 490 && r < 492;
    endfunction

    function automatic logic [3:0] model_pix(int c, int r);
        int x, n, k, y, nm;
        logic [7:0] pt, cb;
        logic [3:0] cc;
        if (f_vid(c, r)) begin
            if (!r1_blank_n) return r7_bd;
            x  = c - HV;
            n  = x / 16;
            k  = (x / 2) % 8;
            y  = (r - VV) / 2;
            nm = int'(mem[int'(r2_nt) * 1024 + (y / 8) * 32 + n]);
            pt = mem[int'(r4_pg) * 2048 + nm * 8 + y % 8];
            cb = mem[int'(r3_ct) * 64 + nm / 8];
            cc = pt[7 - k] ? cb[7:4] : cb[3:0];
            return (cc == 4'd0) ? r7_bd : cc;
        end
        if (f_bdr(c, r)) return r7_bd;
        return 4'd0;
    endfunction

    // Expected read strobe / address for the column currently driven.
    function automatic bit model_rd(int c, int r);
        int fo;
        fo = c - (HV - 16);
        if (!reset || !r1_blank_n) return 1'b0;
        if (r < VV || r >= VV + 384 || fo < 0 || fo >= 512) return 1'b0;
        return (fo % 16 == 0) || (fo % 16 == 2) || (fo % 16 == 3);
    endfunction

    function automatic logic [13:0] model_addr(int c, int r);
        int fo, n, y, nm;
        fo = c - (HV - 16);
        n  = fo / 16;
        y  = (r - VV) / 2;
        nm = int'(mem[int'(r2_nt) * 1024 + (y / 8) * 32 + n]);
        case (fo % 16)
            0:       return 14'(int'(r2_nt) * 1024 + (y / 8) * 32 + n);
            2:       return 14'(int'(r4_pg) * 2048 + nm * 8 + y % 8);
            default: return 14'(int'(r3_ct) * 64 + nm / 8);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hsync_o", 32'(hsync_o), 32'(e.hs));
            check("vsync_o", 32'(vsync_o), 32'(e.vs));
            check("vid_o", 32'(vid_o), 32'(e.vid));
            if (e.chk) check($sformatf("color@col%0d", e.col), 32'(color), 32'(e.color));
            else       check("color_known", 32'($isunknown(color)), 32'd0);
            if (e.col >= HV && e.col < HV + 16) obs[e.col - HV] = color;
        end
    endtask

    // One full 800-column line; reset is pulled low at column rst_lo and
    // released at rst_hi (negative = not used).
    task automatic run_line(input int r, input int rst_lo, input int rst_hi);
        exp_t e;
        bit   post_rst;
        bit   erd;
        post_rst = 1'b0;
        rd_count = 0;
        rd_seen  = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            pop_compare();
            if (c == rst_lo) reset = 1'b0;
            if (c == rst_hi) begin
                reset    = 1'b1;
                post_rst = 1'b1;
            end
            col        = 10'(c);
            row        = 10'(r);
            vid_active = f_vid(c, r);
            bdr_active = f_bdr(c, r);
            hsync      = f_hs(c);
            vsync      = f_vs(r);
            e.col = c;
            if (!reset) begin
                e.color = 4'd0; e.hs = 1'b0; e.vs = 1'b0; e.vid = 1'b0; e.chk = 1'b1;
            end else begin
                e.color = model_pix(c, r);
                e.hs    = f_hs(c);
                e.vs    = f_vs(r);
                e.vid   = f_vid(c, r);
                e.chk   = !post_rst;
            end
            sb.push_back(e);
            #1;
            erd = model_rd(c, r);
            check("vram_rd", 32'(vram_rd), 32'(erd));
            if (erd) check($sformatf("vram_addr@col%0d", c), 32'(vram_addr), 32'(model_addr(c, r)));
            if (vram_rd === 1'b1) begin
                if (rd_seen < 3) rd_addrs[rd_seen] = vram_addr;
                rd_seen++;
                rd_count++;
            end
        end
    endtask

    initial begin
        logic [3:0] shape [16];
        shape = '{4'd15, 4'd15, 4'd4, 4'd4, 4'd15, 4'd15, 4'd4, 4'd4,
                  4'd4, 4'd4, 4'd15, 4'd15, 4'd4, 4'd4, 4'd15, 4'd15};

        reset = 1'b0;
        col = '0; row = '0;
        vid_active = 1'b0; bdr_active = 1'b0; hsync = 1'b0; vsync = 1'b0;
        r1_blank_n = 1'b1;
        r2_nt = 4'd3; r3_ct = 8'h80; r4_pg = 3'd1; r7_bd = 4'd2;
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
        mem[14'h0C00] = 8'h41;
        mem[14'h0A08] = 8'hA5;
        mem[14'h2008] = 8'hF4;

        // Reset held across a whole active line.
        run_line(50, 0, -1);
        check("reset_rd_count", 32'(rd_count), 32'd0);
        reset = 1'b1;

        // Address sequence and pixel shape on the first active line.
        run_line(48, -1, -1);
        check("rd_count_line48", 32'(rd_count), 32'd96);
        check("addr_p0", 32'(rd_addrs[0]), 32'h0C00);
        check("addr_p2", 32'(rd_addrs[1]), 32'h0A08);
        check("addr_p3", 32'(rd_addrs[2]), 32'h2008);
        for (int i = 0; i < 16; i++) check($sformatf("shape_px%0d", i), 32'(obs[i]), 32'(shape[i]));

        // Transparent foreground falls through to the backdrop.
        mem[14'h0A08] = 8'hFF;
        mem[14'h2008] = 8'h01;
        r7_bd = 4'd7;
        run_line(48, -1, -1);
        for (int i = 0; i < 16; i++) check($sformatf("transp_px%0d", i), 32'(obs[i]), 32'd7);

        // Blanked display: no fetches, backdrop on active pixels.
        r1_blank_n = 1'b0;
        run_line(100, -1, -1);
        check("blank_rd_count", 32'(rd_count), 32'd0);
        for (int i = 0; i < 16; i++) check($sformatf("blank_px%0d", i), 32'(obs[i]), 32'd7);
        r1_blank_n = 1'b1;

        // Border-only lines above and below the active area.
        run_line(30, -1, -1);
        check("border_top_rd_count", 32'(rd_count), 32'd0);
        run_line(440, -1, -1);
        check("border_bot_rd_count", 32'(rd_count), 32'd0);

        // Other register settings, including the last active line.
        r2_nt = 4'd5; r4_pg = 3'd2; r3_ct = 8'h11; r7_bd = 4'd9;
        run_line(200, -1, -1);
        check("rd_count_line200", 32'(rd_count), 32'd96);
        run_line(VV + 383, -1, -1);
        check("rd_count_last", 32'(rd_count), 32'd96);

        // Vertical sync line.
        run_line(490, -1, -1);
        check("vsync_rd_count", 32'(rd_count), 32'd0);

        // Reset pulse mid-line; following line must be exact.
        run_line(100, 200, 300);
        run_line(101, -1, -1);
        check("post_reset_rd_count", 32'(rd_count), 32'd96);

        @(negedge clk);
        pop_compare();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vdp_g1_render.md
# vdp_g1_render

- Graphics I (TMS9918 mode 0) pixel renderer for the vdp99 display path.
- Sits directly downstream of the VGA sync generator: consumes its `col`/`row`/`vid_active`/`bdr_active`/`hsync`/`vsync` and fetches name, pattern and color bytes from VRAM over a single read port.
- Emits a registered 4-bit color index, pixel-doubled (256x192 → 512x384), with sync signals delayed to stay aligned.

## Interface
Parameters:
- `HVID_BEGIN`, 64: first `col` of the active video region.
- `VVID_BEGIN`, 48: first `row` of the active video region.

Ports (reset is asynchronous, active-low):
- `clk`  in  1  pixel clock (25 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `col`  in  10  current column from the sync generator.
- `row`  in  10  current row from the sync generator.
- `vid_active`, `bdr_active`, `hsync`, `vsync`  in  1 each  from the sync generator, same cycle as `col`/`row`.
- `r1_blank_n`  in  1  0 = display blanked (VDP R1 bit 6).
- `r2_nt`  in  4  name table base (addr[13:10]).
- `r3_ct`  in  8  color table base (addr[13:6]).
- `r4_pg`  in  3  pattern generator base (addr[13:11]).
- `r7_bd`  in  4  backdrop color.
- `vram_addr`  out  14  VRAM read address.
- `vram_rd`  out  1  read strobe, one clock per access.
- `vram_data`  in  8  read data, valid the clock after `vram_rd`.
- `color`  out  4  pixel color index.
- `hsync_o`, `vsync_o`, `vid_o`  out  1 each  inputs delayed one clock.

## Operation
Coordinates:
- y = (row − VVID_BEGIN) >> 1.
- Fetch offset f = col − (HVID_BEGIN − 16); tile n = f[8:4], phase p = f[3:0].
- Fetch window: row in [VVID_BEGIN, VVID_BEGIN+384) and f in [0, 512), i.e. n = 0..31, tile n fetched during the 16 clocks before it is displayed. Outside the window, or when `r1_blank_n`=0, `vram_rd`=0.

Per-tile sequence (p):
- 0: `vram_addr` = {r2_nt, y[7:3], n}, `vram_rd`=1.
- 1: name ← `vram_data`.
- 2: `vram_addr` = {r4_pg, name, y[2:0]}, `vram_rd`=1.
- 3: pattern ← `vram_data`; `vram_addr` = {r3_ct, name[7:3]}, `vram_rd`=1.
- 4: colbyte ← `vram_data`.
- 15: shifter ← pattern, fg ← colbyte[7:4], bg ← colbyte[3:0].
- Other phases: `vram_rd`=0, `vram_addr` holds its last value.
- Registers are sampled at the phase that uses them; changes mid-line take effect on the next access.

Pixel output, registered on each clock from the input signals:
- `vid_active`=1 and `r1_blank_n`=1: c = shifter[7] ? fg : bg; `color` = (c == 0) ? r7_bd : c.
- `vid_active`=1 and `r1_blank_n`=0: `color` = r7_bd.
- `bdr_active`=1: `color` = r7_bd.
- Otherwise: `color` = 0.
- Shifter shifts left, filling 0, on clocks where (col − HVID_BEGIN)[0] = 1 inside active video. Each source pixel therefore lasts 2 clocks and each tile 16 clocks.

## Timing
- Reset values: all outputs 0; name, pattern, colbyte, shifter, fg, bg are 0.
- Reset asserted mid-line clears state immediately. After release, output is correct from the next full tile fetch; the partial line may show bg/backdrop.
- Latency: `color`, `hsync_o`, `vsync_o`, `vid_o` are exactly 1 clock behind the input `col`. `color` for input col = HVID_BEGIN+16n+2k is pixel k of tile n.
- VRAM: exactly 3 reads per tile, 96 per active line, 0 on border and blanking lines. Phases 5..14 are free for CPU access.
- Boundaries:
  - f = 511 is the last fetch clock.
  - For row ≥ VVID_BEGIN+384 no fetch occurs; the shifter is never loaded on those lines.
  - n = 31 uses address column 31; n never wraps.
  - On each line, the load at f=15 for tile 0 precedes the first active pixel by one clock.

## Test plan
- Reset: hold `reset`=0 with sync inputs toggling → `color`=0, `vram_rd`=0, `hsync_o`=`vsync_o`=0.
- Address sequence: r2_nt=3, r4_pg=1, r3_ct=0x80, row=48 (y=0), VRAM name@0x0C00=0x41 → for tile 0:
  - p0 addr 0x0C00;
  - p2 addr 0x0A08;
  - p3 addr 0x2008;
  - 3 strobes per tile, 96 per line.
- Pixel shape: pattern 0xA5, colbyte 0xF4 (fg=15, bg=4), tile 0 → `color` from col 64 (1 clock late) = 15,15,4,4,15,15,4,4,4,4,15,15,4,4,15,15.
- Transparency: colbyte 0x01 (fg 0), pattern 0xFF, r7_bd=7 → all 16 tile-0 pixels = 7.
- Blank/border: r1_blank_n=0 on an active line → `vram_rd` never asserts, active pixels = r7_bd. Border columns always = r7_bd; sync blanking region = 0.
- Reset mid-line: deassert reset at col 300 of row 100 → no X on outputs; row 101 matches the golden model exactly.
